sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one combinational sprite bitmap ROM (8-bit address, 8-bit data) between N sprite renderers.
- Lets several tanks and sprites fetch scanline bits from a single bitmap table during the hsync/load window.
- Each requester holds a request and address; the arbiter grants round-robin, drives the ROM address, registers the returned byte and pulses a per-requester ack with the data.
- Sits between the per-sprite controllers and the bitmap ROM in the top level.

Parameters:
- N, 4, number of requesters (2..8).
- ADDR_W, 8, ROM address width; {bitmap_num[2:0], row/half[4:0]}.
- DATA_W, 8, ROM data width.

Ports:
- clk  input  1  pixel clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- req  input  N  per-requester fetch request; held until that requester's ack.
- req_addr  input  N*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- rom_addr  output  ADDR_W  registered address to the ROM.
- rom_data  input  DATA_W  combinational ROM output for rom_addr.
- ack  output  N  one-hot, one-cycle pulse; rsp_data is valid for the indexed requester while high.
- rsp_data  output  DATA_W  registered ROM byte, broadcast to all requesters.
- busy  output  1  high while any fetch is in flight or being acked.

Behaviour:
- Reset, asynchronous on reset low:
  - rom_addr=0, rsp_data=0, ack=0, busy=0.
  - rr pointer ptr=0, inflight_valid=0, inflight_id=0.
  - Reset mid-fetch drops the fetch: no ack is issued after reset release, and requesters must re-request.
- Eligibility mask: requester i is eligible at an edge when req[i]=1 AND NOT (inflight_valid && inflight_id==i) AND NOT ack[i]. This masking prevents a duplicate grant while a held req awaits or sees its ack.
- Arbitration at each posedge:
  - If any eligible requester exists, pick the first eligible index scanning ptr, ptr+1, ... wrapping mod N.
  - On a grant: rom_addr<=req_addr[winner], inflight_id<=winner, inflight_valid<=1, ptr<=(winner+1) mod N.
  - With no eligible requester: inflight_valid<=0; rom_addr and ptr hold.
- Response stage, same posedge, using the previous-cycle inflight:
  - If inflight_valid: rsp_data<=rom_data, ack<=onehot(inflight_id).
  - Otherwise ack<=0 and rsp_data holds.
- Latency:
  - req sampled at edge E0 → rom_addr valid after E0 → ack and rsp_data visible after E1, i.e. 2 clocks.
  - A requester that drops req on seeing ack (registered at E2) is never regranted.
- Throughput: one grant per clock aggregate (fully pipelined). A single requester gets at most one fetch per 3 clocks because of masking.
- Simultaneous events:
  - A new grant and an ack of the previous grant occur on the same edge.
  - ack is never asserted for two requesters at once.
  - A req dropped before it is granted is simply skipped; there is no error and no ack.
- busy = inflight_valid | (ack != 0).
- Widths: ptr and inflight_id are clog2(N) bits. The wrap is explicit mod N, so it is correct for non-power-of-two N.
- req_addr is sampled only at the grant edge, so later changes do not affect the outstanding fetch.

Decomposition:
- Shared package holds:
  - SPRITE_ROM_ADDR_W=8 and SPRITE_ROM_DATA_W=8.
  - Default requester count.
  - Helper function onehot(idx, N).
- One natural sub-module: rr_pick (combinational). Inputs: eligible[N], ptr. Outputs: any, winner index. It is reusable by other shared-resource arbiters.
- The top holds the pipeline registers and the pointer.

Test Plan:
- Bench ROM model: rom_data = rom_addr ^ 8'hA5.
- Scenario 1, single request: after reset release, req=4'b0001 with addr0=8'h12 held.
  - rom_addr=8'h12 after the 1st edge.
  - ack=4'b0001 and rsp_data=8'hB7 after the 2nd edge.
  - Requester drops req on ack; there is no second ack.
- Scenario 2, all four request together: addrs 8'h00/8'h21/8'h42/8'h63, each held until its own ack.
  - Acks arrive in order 0,1,2,3 on consecutive cycles.
  - rsp_data sequence is A5,84,E7,C6.
  - ptr ends at 0.
- Scenario 3, round-robin fairness: req[0] and req[2] each re-request immediately after ack, for 20 fetches.
  - Grants alternate 0,2,0,2.
  - Neither requester waits more than 3 cycles between its own consecutive acks.
- Scenario 4, held-req duplicate guard: req[1] is held high 6 cycles with no other requesters.
  - Exactly 2 acks appear, spaced 3 cycles apart.
  - There are never two back-to-back acks to requester 1.
- Scenario 5, reset mid-operation: assert reset low 1 cycle after granting requester 3.
  - Outputs read 0 immediately (asynchronous).
  - After release with req=0, no ack appears for 5 cycles and busy=0.
- Scenario 6, address change after grant: requester 0 (addr 8'h10) is granted, then its addr changes to 8'h55 the next cycle.
  - rsp_data=8'hB5, computed from the latched 8'h10.

Source files
------------

// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants and helpers for the sprite bitmap ROM arbiter and its sub-blocks.
// The requester count is capped at 8, so the one-hot helper returns a fixed 8-bit vector.
package sprite_rom_arbiter_pkg;

    localparam int SPRITE_ROM_ADDR_W    = 8;
    localparam int SPRITE_ROM_DATA_W    = 8;
    localparam int SPRITE_ROM_DEFAULT_N = 4;
    localparam int SPRITE_ROM_MAX_N     = 8;

    // One-hot decode of idx, limited to the low n bits.
    function automatic logic [SPRITE_ROM_MAX_N-1:0] onehot(input logic [2:0] idx, input int n);
        logic [SPRITE_ROM_MAX_N-1:0] vec;
        vec = {SPRITE_ROM_MAX_N{1'b0}};
        for (int i = 0; i < SPRITE_ROM_MAX_N; i++) begin
            if ((i < n) && (idx == i[2:0])) begin
                vec[i] = 1'b1;
            end else begin
                vec[i] = 1'b0;
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible index at or after ptr, wrapping mod N.
// Reusable by any shared-resource arbiter that keeps its own pointer.
module sprite_rom_arbiter_rr_pick
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int N     = SPRITE_ROM_DEFAULT_N,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] winner
);

    // Scan from ptr upward; the modulo keeps the wrap correct for non-power-of-two N.
    always_comb begin
        int idx;
        any    = 1'b0;
        winner = {PTR_W{1'b0}};
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && eligible[idx]) begin
                any    = 1'b1;
                winner = idx[PTR_W-1:0];
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one combinational sprite bitmap ROM among N renderers.
// Two-stage pipeline: grant/address at one edge, registered data and ack at the next.
module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int N      = SPRITE_ROM_DEFAULT_N,
    parameter int ADDR_W = SPRITE_ROM_ADDR_W,
    parameter int DATA_W = SPRITE_ROM_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N*ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [N-1:0]        ack,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                busy
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0]            ptr_r;
    logic [PTR_W-1:0]            inflight_id_r;
    logic                        inflight_valid_r;
    logic [ADDR_W-1:0]           rom_addr_r;
    logic [N-1:0]                ack_r;
    logic [DATA_W-1:0]           rsp_data_r;
    logic                        busy_r;

    logic [N-1:0]                eligible_s;
    logic                        any_s;
    logic [PTR_W-1:0]            winner_s;
    logic [PTR_W-1:0]            next_ptr_s;
    logic [ADDR_W-1:0]           grant_addr_s;
    logic [SPRITE_ROM_MAX_N-1:0] onehot_s;
    logic [N-1:0]                ack_next_s;

    // Mask out the requester still in flight or being acked so a held req is not granted twice.
    always_comb begin
        eligible_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            eligible_s[i] = req[i] & ~(inflight_valid_r && (inflight_id_r == PTR_W'(i))) & ~ack_r[i];
        end
    end

    sprite_rom_arbiter_rr_pick #(.N(N), .PTR_W(PTR_W)) u_rr_pick (
        .eligible (eligible_s),
        .ptr      (ptr_r),
        .any      (any_s),
        .winner   (winner_s)
    );

    // Winner's address, next pointer and the ack vector for the fetch now completing.
    always_comb begin
        grant_addr_s = req_addr[ADDR_W-1:0];
        for (int i = 0; i < N; i++) begin
            if (winner_s == PTR_W'(i)) begin
                grant_addr_s = req_addr[i*ADDR_W +: ADDR_W];
            end else begin
                grant_addr_s = grant_addr_s;
            end
        end
        if (winner_s == PTR_W'(N - 1)) begin
            next_ptr_s = {PTR_W{1'b0}};
        end else begin
            next_ptr_s = winner_s + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        onehot_s   = onehot(3'(inflight_id_r), N);
        ack_next_s = onehot_s[N-1:0];
    end

    // Grant stage and response stage advance together on every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r            <= {PTR_W{1'b0}};
            inflight_id_r    <= {PTR_W{1'b0}};
            inflight_valid_r <= 1'b0;
            rom_addr_r       <= {ADDR_W{1'b0}};
            ack_r            <= {N{1'b0}};
            rsp_data_r       <= {DATA_W{1'b0}};
            busy_r           <= 1'b0;
        end else begin
            if (any_s) begin
                rom_addr_r    <= grant_addr_s;
                inflight_id_r <= winner_s;
                ptr_r         <= next_ptr_s;
            end else begin
                rom_addr_r    <= rom_addr_r;
                inflight_id_r <= inflight_id_r;
                ptr_r         <= ptr_r;
            end
            inflight_valid_r <= any_s;
            if (inflight_valid_r) begin
                rsp_data_r <= rom_data;
                ack_r      <= ack_next_s;
            end else begin
                rsp_data_r <= rsp_data_r;
                ack_r      <= {N{1'b0}};
            end
            // Next inflight_valid is any_s; next ack is non-zero exactly when inflight_valid_r.
            busy_r <= any_s | inflight_valid_r;
        end
    end

    assign rom_addr = rom_addr_r;
    assign ack      = ack_r;
    assign rsp_data = rsp_data_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a ROM model of rom_data = rom_addr ^ 8'hA5.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  ack;
    logic [7:0]  rsp_data;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int n3, last0, last2, acks4, prev_ack_cyc;
    logic [3:0] exp_ack;
    logic [7:0] exp2 [4];
    logic [3:0] exp4 [6];

    always #5 clk = ~clk;

    assign rom_data = rom_addr ^ 8'hA5;

    sprite_rom_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .ack      (ack),
        .rsp_data (rsp_data),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b0;
        req      = 4'b0000;
        req_addr = 32'h0000_0000;
        exp2     = '{8'hA5, 8'h84, 8'hE7, 8'hC6};
        exp4     = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'h00);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_rsp", 32'(rsp_data), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;

        // Scenario 1: single request
        @(negedge clk);
        req      = 4'b0001;
        req_addr = 32'h0000_0012;
        @(negedge clk);
        check("s1_rom_addr", 32'(rom_addr), 32'h12);
        check("s1_ack_early", 32'(ack), 32'h0);
        check("s1_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("s1_ack", 32'(ack), 32'h1);
        check("s1_rsp", 32'(rsp_data), 32'hB7);
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("s1_no_second_ack", 32'(ack), 32'h0);
        end
        check("s1_idle_busy", 32'(busy), 32'h0);

        // Scenario 2: all four at once, pointer restarted from 0
        reset = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        req      = 4'b1111;
        req_addr = 32'h6342_2100;
        @(negedge clk);
        check("s2_rom_addr0", 32'(rom_addr), 32'h00);
        check("s2_ack_early", 32'(ack), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("s2_ack_order", 32'(ack), 32'(1) << k);
            check("s2_rsp", 32'(rsp_data), 32'(exp2[k]));
            req[k] = 1'b0;
        end
        check("s2_ptr", 32'(dut.ptr_r), 32'h0);
        @(negedge clk);
        check("s2_done_ack", 32'(ack), 32'h0);
        check("s2_done_busy", 32'(busy), 32'h0);

        // Scenario 3: requesters 0 and 2 keep requesting
        n3       = 0;
        last0    = -1;
        last2    = -1;
        exp_ack  = 4'b0001;
        req      = 4'b0101;
        req_addr = 32'h0032_0030;
        for (int cyc = 0; cyc < 80 && n3 < 20; cyc++) begin
            @(negedge clk);
            if (ack != 4'b0000) begin
                check("s3_order", 32'(ack), 32'(exp_ack));
                check("s3_rsp", 32'(rsp_data), exp_ack[0] ? 32'h95 : 32'h97);
                if (ack[0]) begin
                    if (last0 >= 0) check("s3_wait0", 32'(cyc - last0 <= 3), 32'h1);
                    last0 = cyc;
                end else begin
                    if (last2 >= 0) check("s3_wait2", 32'(cyc - last2 <= 3), 32'h1);
                    last2 = cyc;
                end
                exp_ack = (exp_ack == 4'b0001) ? 4'b0100 : 4'b0001;
                n3++;
            end
        end
        req = 4'b0000;
        check("s3_fetch_count", 32'(n3), 32'd20);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("s3_no_stray_ack", 32'(ack), 32'h0);
        end

        // Scenario 4: requester 1 held for 6 cycles
        acks4        = 0;
        prev_ack_cyc = -10;
        req          = 4'b0010;
        req_addr     = 32'h0000_4400;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 6) begin
                check("s4_ack_pattern", 32'(ack), 32'(exp4[c]));
            end else begin
                check("s4_ack_after_drop", 32'(ack), 32'h0);
            end
            if (ack[1]) begin
                if (acks4 > 0) check("s4_spacing", 32'(c - prev_ack_cyc), 32'd3);
                check("s4_rsp", 32'(rsp_data), 32'hE1);
                prev_ack_cyc = c;
                acks4++;
            end
            if (c == 5) req = 4'b0000;
        end
        check("s4_ack_count", 32'(acks4), 32'd2);

        // Scenario 5: reset right after granting requester 3
        req      = 4'b1000;
        req_addr = 32'h7700_0000;
        @(negedge clk);
        check("s5_rom_addr", 32'(rom_addr), 32'h77);
        check("s5_busy_before", 32'(busy), 32'h1);
        reset = 1'b0;
        req   = 4'b0000;
        #1;
        check("s5_async_rom_addr", 32'(rom_addr), 32'h00);
        check("s5_async_ack", 32'(ack), 32'h0);
        check("s5_async_rsp", 32'(rsp_data), 32'h00);
        check("s5_async_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("s5_no_ack", 32'(ack), 32'h0);
            check("s5_busy", 32'(busy), 32'h0);
        end

        // Scenario 6: address changes after the grant
        req      = 4'b0001;
        req_addr = 32'h0000_0010;
        @(negedge clk);
        check("s6_rom_addr", 32'(rom_addr), 32'h10);
        req_addr = 32'h0000_0055;
        @(negedge clk);
        check("s6_ack", 32'(ack), 32'h1);
        check("s6_rsp", 32'(rsp_data), 32'hB5);
        check("s6_rom_addr_hold", 32'(rom_addr), 32'h10);
        req = 4'b0000;
        @(negedge clk);
        check("s6_ack_clear", 32'(ack), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
